sys_ctrl_gen: RTL and testbench
===============================

Name: sys_ctrl_gen

Overview:
- Parametrised command controller between the UART RX/TX byte streams, the register file and the ALU.
- Decodes framed commands: register write, register read, ALU op with operands, ALU op without operands.
- Returns results as a multi-byte TX stream with backpressure.
- Adds argument/response timeouts, address range checks and an error-response byte.

Parameters:
DATA_W, 8, byte width of RX/TX/register-file data
ADDR_W, 4, register-file address width
FUN_W, 4, ALU function code width
OUT_BYTES, 2, ALU result width in DATA_W units (ALU_OUT width = DATA_W*OUT_BYTES)
TIMEOUT, 255, cycles allowed waiting for an argument byte or a response before abort
CMD_WR, 8'hAA, register write command
CMD_RD, 8'hBB, register read command
CMD_ALU_OP, 8'hCC, ALU command with operands
CMD_ALU_NOP, 8'hDD, ALU command without operands
ERR_CODE, 8'hEE, byte transmitted on any error

Ports:
CLK  in  1  system clock
RST  in  1  synchronous active-high reset
RX_P_DATA  in  DATA_W  received byte
RX_D_VLD  in  1  one-cycle strobe, RX_P_DATA valid
RdData  in  DATA_W  register-file read data
RdData_Valid  in  1  read data valid strobe
ALU_OUT  in  DATA_W*OUT_BYTES  ALU result
OUT_Valid  in  1  ALU result valid strobe
F_FULL  in  1  TX FIFO full (backpressure)
ALU_FUN  out  FUN_W  ALU function
ALU_EN  out  1  ALU enable
CLK_EN  out  1  ALU clock-gate enable
Address  out  ADDR_W  register-file address
WrEN  out  1  register write strobe
RdEn  out  1  register read strobe
WrData  out  DATA_W  register write data
TX_P_Data  out  DATA_W  TX FIFO write data
TX_D_VLD  out  1  TX FIFO write strobe
clk_div_en  out  1  UART clock divider enable
CMD_ERR  out  1  one-cycle pulse on each error event

Behaviour:
- All outputs are registered. Each output is asserted in the cycle after the qualifying input is sampled.
- Reset (RST=1 at a CLK edge) takes priority over everything:
  - state goes to IDLE; timeout counter and TX byte index clear;
  - all outputs 0 except clk_div_en=1;
  - any in-flight command is discarded; no TX byte is emitted.
- clk_div_en is constant 1 outside reset.
- States: IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, OPA, OPB, FUN, ALU_WAIT, TX_RES, TX_ERR.
- IDLE, on RX_D_VLD:
  - CMD_WR->WR_ADDR; CMD_RD->RD_ADDR; CMD_ALU_OP->OPA; CMD_ALU_NOP->FUN;
  - any other byte->TX_ERR.
- Address capture (WR_ADDR, RD_ADDR): a byte with any bit set above bit ADDR_W-1 is out of range ->TX_ERR.
- WR_ADDR: latch the address, go to WR_DATA.
- WR_DATA: on RX_D_VLD, one-cycle WrEN=1 with Address=latched address and WrData=byte, then go to IDLE. No TX response.
- RD_ADDR: one-cycle RdEn=1 with Address=byte, then go to RD_WAIT.
- RD_WAIT: capture RdData on RdData_Valid, then go to TX_RES with a 1-byte length.
- OPA / OPB: on RX_D_VLD, write the byte to address 0 (OPA) or address 1 (OPB) with WrEN pulsed one cycle. OPA->OPB, OPB->FUN.
- FUN:
  - CLK_EN=1 on entry;
  - on RX_D_VLD, ALU_FUN=byte[FUN_W-1:0] and ALU_EN=1 for one cycle, then go to ALU_WAIT;
  - FUN_W upper bits of the byte are ignored.
- ALU_WAIT: CLK_EN=1; capture ALU_OUT on OUT_Valid, then go to TX_RES with length OUT_BYTES.
- TX_RES:
  - emits the captured bytes least-significant first, one byte per cycle, each with TX_D_VLD=1;
  - while F_FULL=1, emits nothing and holds the index;
  - after the last byte, returns to IDLE;
  - CLK_EN stays 1 until the ALU result is fully sent, then drops to 0.
- TX_ERR: CMD_ERR pulses on entry; sends ERR_CODE once F_FULL=0, then returns to IDLE.
- Timeout:
  - a counter clears on every state entry and on every accepted byte;
  - if it reaches TIMEOUT in any argument or wait state (WR_ADDR through ALU_WAIT), go to TX_ERR;
  - a strobe arriving in the same cycle as the timeout wins (it is accepted and there is no error).
- F_FULL only stalls TX_RES/TX_ERR. The F_FULL gating of register writes used in the previous generation is removed.
- RX_D_VLD in RD_WAIT, ALU_WAIT, TX_RES or TX_ERR is dropped silently.
- Spurious RdData_Valid or OUT_Valid in other states is ignored.
- Latency:
  - command byte to next state: 1 cycle;
  - RdData_Valid to first TX_D_VLD: 2 cycles;
  - OUT_Valid to first TX_D_VLD: 2 cycles.

Test Plan:
- Write then read: RX AA,05,3C, then BB,05; model returns 3C -> WrEN pulse with Address=5, WrData=3C; RdEn with Address=5; one TX byte 3C; no CMD_ERR.
- ALU with operands, OUT_BYTES=2: RX CC,12,34,00; ALU_OUT=0x0046 -> writes 12@0 and 34@1; ALU_EN pulse with ALU_FUN=0; TX 46 then 00; CLK_EN low after the last byte.
- Backpressure: DD,02 with ALU_OUT=0xBEEF; F_FULL=1 for 3 cycles after OUT_Valid -> no TX while full; then EF, BE on consecutive cycles.
- Errors: RX 5A in IDLE -> CMD_ERR pulse and TX EE. RX BB,20 (out of range for ADDR_W=4) -> TX EE, no RdEn.
- Timeout, TIMEOUT=8: RX AA only -> after 8 idle cycles TX EE and return to IDLE. A second run with RX_D_VLD arriving on the timeout cycle -> byte accepted, no error.
- Reset mid-TX_RES after the first byte -> no further TX_D_VLD; outputs return to reset values; the next command works normally.

Source files
------------

// File: rtl/sys_ctrl_gen.sv
// sys_ctrl_gen: command controller between UART RX/TX byte streams, register file and ALU
// Ports: CLK/RST (sync active-high); RX_P_DATA/RX_D_VLD command bytes in;
// RdData/RdData_Valid and ALU_OUT/OUT_Valid results in; F_FULL TX backpressure;
// ALU_FUN/ALU_EN/CLK_EN ALU control; Address/WrEN/RdEn/WrData register-file access;
// TX_P_Data/TX_D_VLD response bytes; clk_div_en UART divider enable; CMD_ERR error pulse.
module sys_ctrl_gen #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4,
  parameter int FUN_W = 4,
  parameter int OUT_BYTES = 2,
  parameter int TIMEOUT = 255,
  parameter logic [DATA_W-1:0] CMD_WR = 8'hAA,
  parameter logic [DATA_W-1:0] CMD_RD = 8'hBB,
  parameter logic [DATA_W-1:0] CMD_ALU_OP = 8'hCC,
  parameter logic [DATA_W-1:0] CMD_ALU_NOP = 8'hDD,
  parameter logic [DATA_W-1:0] ERR_CODE = 8'hEE
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic [DATA_W-1:0]           RX_P_DATA,
  input  logic                        RX_D_VLD,
  input  logic [DATA_W-1:0]           RdData,
  input  logic                        RdData_Valid,
  input  logic [DATA_W*OUT_BYTES-1:0] ALU_OUT,
  input  logic                        OUT_Valid,
  input  logic                        F_FULL,
  output logic [FUN_W-1:0]            ALU_FUN,
  output logic                        ALU_EN,
  output logic                        CLK_EN,
  output logic [ADDR_W-1:0]           Address,
  output logic                        WrEN,
  output logic                        RdEn,
  output logic [DATA_W-1:0]           WrData,
  output logic [DATA_W-1:0]           TX_P_Data,
  output logic                        TX_D_VLD,
  output logic                        clk_div_en,
  output logic                        CMD_ERR
);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam int IW = OUT_BYTES > 1 ? $clog2(OUT_BYTES) : 1;
  typedef enum logic [3:0] {
    IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, OPA, OPB, FUN, ALU_WAIT, TX_RES, TX_ERR
  } state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d, last_q, last_d;
  logic [OUT_BYTES-1:0][DATA_W-1:0] res_q, res_d;
  logic alu_q, alu_d;
  logic [FUN_W-1:0] alu_fun_q, alu_fun_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d, tx_data_q, tx_data_d;
  logic alu_en_q, alu_en_d, clk_en_q, clk_en_d, wr_en_q, wr_en_d, rd_en_q, rd_en_d;
  logic tx_vld_q, tx_vld_d, clk_div_en_q, cmd_err_q, cmd_err_d;
  logic timed, to, oor;
  assign timed = state_q != IDLE && state_q != TX_RES && state_q != TX_ERR;
  assign to = cnt_q == CW'(TIMEOUT - 1);
  assign oor = |(RX_P_DATA >> ADDR_W);
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    last_d = last_q;
    res_d = res_q;
    alu_d = alu_q;
    alu_fun_d = alu_fun_q;
    addr_d = addr_q;
    wr_data_d = wr_data_q;
    tx_data_d = tx_data_q;
    alu_en_d = 1'b0;
    wr_en_d = 1'b0;
    rd_en_d = 1'b0;
    tx_vld_d = 1'b0;
    case (state_q)
      IDLE: if (RX_D_VLD)
        state_d = RX_P_DATA == CMD_WR ? WR_ADDR : RX_P_DATA == CMD_RD ? RD_ADDR :
                  RX_P_DATA == CMD_ALU_OP ? OPA : RX_P_DATA == CMD_ALU_NOP ? FUN : TX_ERR;
      WR_ADDR: if (RX_D_VLD) begin
        state_d = oor ? TX_ERR : WR_DATA;
        addr_d = oor ? addr_q : RX_P_DATA[ADDR_W-1:0];
      end else if (to) state_d = TX_ERR;
      WR_DATA: if (RX_D_VLD) begin
        state_d = IDLE;
        wr_en_d = 1'b1;
        wr_data_d = RX_P_DATA;
      end else if (to) state_d = TX_ERR;
      RD_ADDR: if (RX_D_VLD) begin
        state_d = oor ? TX_ERR : RD_WAIT;
        rd_en_d = !oor;
        addr_d = oor ? addr_q : RX_P_DATA[ADDR_W-1:0];
      end else if (to) state_d = TX_ERR;
      RD_WAIT: if (RdData_Valid) begin
        state_d = TX_RES;
        res_d = '0;
        res_d[0] = RdData;
        last_d = '0;
        alu_d = 1'b0;
      end else if (to) state_d = TX_ERR;
      OPA, OPB: if (RX_D_VLD) begin
        state_d = state_q == OPA ? OPB : FUN;
        wr_en_d = 1'b1;
        addr_d = state_q == OPA ? ADDR_W'(0) : ADDR_W'(1);
        wr_data_d = RX_P_DATA;
      end else if (to) state_d = TX_ERR;
      FUN: if (RX_D_VLD) begin
        state_d = ALU_WAIT;
        alu_en_d = 1'b1;
        alu_fun_d = RX_P_DATA[FUN_W-1:0];
      end else if (to) state_d = TX_ERR;
      ALU_WAIT: if (OUT_Valid) begin
        state_d = TX_RES;
        res_d = ALU_OUT;
        last_d = IW'(OUT_BYTES - 1);
        alu_d = 1'b1;
      end else if (to) state_d = TX_ERR;
      TX_RES: if (!F_FULL) begin
        tx_vld_d = 1'b1;
        tx_data_d = res_q[idx_q];
        idx_d = idx_q == last_q ? '0 : idx_q + 1'b1;
        state_d = idx_q == last_q ? IDLE : TX_RES;
      end
      TX_ERR: if (!F_FULL) begin
        tx_vld_d = 1'b1;
        tx_data_d = ERR_CODE;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // every accepted byte changes state, so a state change also covers the byte-accept clear
    cnt_d = (timed && state_d == state_q) ? cnt_q + 1'b1 : '0;
    clk_en_d = state_d == FUN || state_d == ALU_WAIT || (state_d == TX_RES && alu_d);
    cmd_err_d = state_d == TX_ERR && state_q != TX_ERR;
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q <= '0;
      idx_q <= '0;
      last_q <= '0;
      res_q <= '0;
      alu_q <= 1'b0;
      alu_fun_q <= '0;
      addr_q <= '0;
      wr_data_q <= '0;
      tx_data_q <= '0;
      alu_en_q <= 1'b0;
      clk_en_q <= 1'b0;
      wr_en_q <= 1'b0;
      rd_en_q <= 1'b0;
      tx_vld_q <= 1'b0;
      clk_div_en_q <= 1'b1;
      cmd_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      last_q <= last_d;
      res_q <= res_d;
      alu_q <= alu_d;
      alu_fun_q <= alu_fun_d;
      addr_q <= addr_d;
      wr_data_q <= wr_data_d;
      tx_data_q <= tx_data_d;
      alu_en_q <= alu_en_d;
      clk_en_q <= clk_en_d;
      wr_en_q <= wr_en_d;
      rd_en_q <= rd_en_d;
      tx_vld_q <= tx_vld_d;
      clk_div_en_q <= 1'b1;
      cmd_err_q <= cmd_err_d;
    end
  end
  assign ALU_FUN = alu_fun_q;
  assign ALU_EN = alu_en_q;
  assign CLK_EN = clk_en_q;
  assign Address = addr_q;
  assign WrEN = wr_en_q;
  assign RdEn = rd_en_q;
  assign WrData = wr_data_q;
  assign TX_P_Data = tx_data_q;
  assign TX_D_VLD = tx_vld_q;
  assign clk_div_en = clk_div_en_q;
  assign CMD_ERR = cmd_err_q;
endmodule

// File: tb/tb_sys_ctrl_gen.sv
// tb_sys_ctrl_gen: table-driven directed bench for sys_ctrl_gen with TIMEOUT=8
module tb_sys_ctrl_gen;
  logic CLK = 1'b0, RST;
  logic [7:0] RX_P_DATA, RdData, WrData, TX_P_Data;
  logic RX_D_VLD, RdData_Valid, OUT_Valid, F_FULL;
  logic [15:0] ALU_OUT;
  logic [3:0] ALU_FUN, Address;
  logic ALU_EN, CLK_EN, WrEN, RdEn, TX_D_VLD, clk_div_en, CMD_ERR;
  int n_chk = 0, n_fail = 0;
  always #5 CLK = ~CLK;
  sys_ctrl_gen #(.TIMEOUT(8)) dut (
    .CLK(CLK), .RST(RST), .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
    .RdData(RdData), .RdData_Valid(RdData_Valid), .ALU_OUT(ALU_OUT), .OUT_Valid(OUT_Valid),
    .F_FULL(F_FULL), .ALU_FUN(ALU_FUN), .ALU_EN(ALU_EN), .CLK_EN(CLK_EN), .Address(Address),
    .WrEN(WrEN), .RdEn(RdEn), .WrData(WrData), .TX_P_Data(TX_P_Data), .TX_D_VLD(TX_D_VLD),
    .clk_div_en(clk_div_en), .CMD_ERR(CMD_ERR)
  );
  // c = expected {WrEN, RdEn, ALU_EN, CLK_EN, TX_D_VLD, CMD_ERR}
  typedef struct {
    string nm;
    logic rv; logic [7:0] rx; logic dv; logic [7:0] rd; logic ov; logic [15:0] ao; logic ff;
    logic [5:0] c; logic [3:0] a; logic [7:0] d; logic [3:0] f; logic [7:0] t;
  } vec_t;
  vec_t tbl[$];
  function automatic vec_t mk(string nm, logic rv, logic [7:0] rx, logic dv, logic [7:0] rd,
                              logic ov, logic [15:0] ao, logic ff, logic [5:0] c,
                              logic [3:0] a, logic [7:0] d, logic [3:0] f, logic [7:0] t);
    vec_t v;
    v.nm = nm; v.rv = rv; v.rx = rx; v.dv = dv; v.rd = rd; v.ov = ov; v.ao = ao; v.ff = ff;
    v.c = c; v.a = a; v.d = d; v.f = f; v.t = t;
    return v;
  endfunction
  function automatic vec_t rb(string nm, logic [7:0] b, logic [5:0] c, logic [3:0] a = 0,
                              logic [7:0] d = 0, logic [3:0] f = 0);
    return mk(nm, 1, b, 0, 0, 0, 0, 0, c, a, d, f, 0);
  endfunction
  function automatic vec_t nx(string nm, logic [5:0] c, logic [7:0] t = 0, logic ff = 0);
    return mk(nm, 0, 0, 0, 0, 0, 0, ff, c, 0, 0, 0, t);
  endfunction
  task automatic step(input vec_t v);
    logic [5:0] ctl;
    logic ok;
    RX_D_VLD = v.rv; RX_P_DATA = v.rx; RdData_Valid = v.dv; RdData = v.rd;
    OUT_Valid = v.ov; ALU_OUT = v.ao; F_FULL = v.ff;
    @(posedge CLK);
    #1;
    ctl = {WrEN, RdEn, ALU_EN, CLK_EN, TX_D_VLD, CMD_ERR};
    ok = ctl == v.c && clk_div_en == 1'b1 &&
         (!(v.c[5] || v.c[4]) || Address == v.a) && (!v.c[5] || WrData == v.d) &&
         (!v.c[3] || ALU_FUN == v.f) && (!v.c[1] || TX_P_Data == v.t);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got ctl=%b addr=%h wd=%h fun=%h tx=%h cde=%b, expected ctl=%b addr=%h wd=%h fun=%h tx=%h cde=1",
               v.nm, ctl, Address, WrData, ALU_FUN, TX_P_Data, clk_div_en, v.c, v.a, v.d, v.f, v.t);
    end
  endtask
  task automatic chk_reset(input string nm);
    n_chk++;
    if ({WrEN, RdEn, ALU_EN, CLK_EN, TX_D_VLD, CMD_ERR, Address, WrData, ALU_FUN, TX_P_Data} != '0
        || clk_div_en !== 1'b1) begin
      n_fail++;
      $display("FAIL %s: got ctl=%b addr=%h wd=%h fun=%h tx=%h cde=%b, expected all zero with cde=1",
               nm, {WrEN, RdEn, ALU_EN, CLK_EN, TX_D_VLD, CMD_ERR}, Address, WrData, ALU_FUN,
               TX_P_Data, clk_div_en);
    end
  endtask
  initial begin
    RST = 1'b1;
    RX_D_VLD = 0; RX_P_DATA = 0; RdData_Valid = 0; RdData = 0; OUT_Valid = 0; ALU_OUT = 0; F_FULL = 0;
    repeat (2) @(posedge CLK);
    #1;
    chk_reset("reset_state");
    RST = 1'b0;
    tbl.push_back(rb("wr_cmd", 8'hAA, 6'b000000));
    tbl.push_back(rb("wr_addr", 8'h05, 6'b000000));
    tbl.push_back(rb("wr_data", 8'h3C, 6'b100000, 4'h5, 8'h3C));
    tbl.push_back(rb("rd_cmd", 8'hBB, 6'b000000));
    tbl.push_back(rb("rd_addr", 8'h05, 6'b010000, 4'h5));
    tbl.push_back(mk("rd_valid", 0, 0, 1, 8'h3C, 0, 0, 0, 6'b000000, 0, 0, 0, 0));
    tbl.push_back(nx("rd_tx", 6'b000010, 8'h3C));
    tbl.push_back(nx("rd_done", 6'b000000));
    tbl.push_back(rb("op_cmd", 8'hCC, 6'b000000));
    tbl.push_back(rb("op_a", 8'h12, 6'b100000, 4'h0, 8'h12));
    tbl.push_back(rb("op_b", 8'h34, 6'b100100, 4'h1, 8'h34));
    tbl.push_back(rb("op_fun", 8'h00, 6'b001100, 0, 0, 4'h0));
    tbl.push_back(nx("op_wait", 6'b000100));
    tbl.push_back(mk("op_valid", 0, 0, 0, 0, 1, 16'h0046, 0, 6'b000100, 0, 0, 0, 0));
    tbl.push_back(nx("op_tx0", 6'b000110, 8'h46));
    tbl.push_back(nx("op_tx1", 6'b000010, 8'h00));
    tbl.push_back(nx("op_done", 6'b000000));
    tbl.push_back(rb("bp_cmd", 8'hDD, 6'b000100));
    tbl.push_back(rb("bp_fun_hi_ignored", 8'h52, 6'b001100, 0, 0, 4'h2));
    tbl.push_back(mk("bp_valid", 0, 0, 0, 0, 1, 16'hBEEF, 1, 6'b000100, 0, 0, 0, 0));
    tbl.push_back(mk("bp_full0_rx_drop", 1, 8'hAA, 0, 0, 0, 0, 1, 6'b000100, 0, 0, 0, 0));
    tbl.push_back(nx("bp_full1", 6'b000100, 0, 1));
    tbl.push_back(nx("bp_full2", 6'b000100, 0, 1));
    tbl.push_back(nx("bp_tx0", 6'b000110, 8'hEF));
    tbl.push_back(nx("bp_tx1", 6'b000010, 8'hBE));
    tbl.push_back(nx("bp_done", 6'b000000));
    tbl.push_back(rb("err_bad_cmd", 8'h5A, 6'b000001));
    tbl.push_back(nx("err_tx", 6'b000010, 8'hEE));
    tbl.push_back(rb("oor_cmd", 8'hBB, 6'b000000));
    tbl.push_back(rb("oor_addr", 8'h20, 6'b000001));
    tbl.push_back(nx("oor_tx", 6'b000010, 8'hEE));
    tbl.push_back(mk("spur_strobes", 0, 0, 1, 8'h55, 1, 16'h1111, 0, 6'b000000, 0, 0, 0, 0));
    tbl.push_back(nx("spur_after", 6'b000000));
    foreach (tbl[i]) step(tbl[i]);
    step(rb("to_cmd", 8'hAA, 6'b000000));
    for (int i = 0; i < 7; i++) step(nx("to_wait", 6'b000000));
    step(nx("to_fire", 6'b000001));
    step(nx("to_tx", 6'b000010, 8'hEE));
    step(rb("race_cmd", 8'hAA, 6'b000000));
    for (int i = 0; i < 7; i++) step(nx("race_wait", 6'b000000));
    step(rb("race_addr", 8'h07, 6'b000000));
    step(rb("race_data", 8'h99, 6'b100000, 4'h7, 8'h99));
    step(rb("rst_cmd", 8'hDD, 6'b000100));
    step(rb("rst_fun", 8'h01, 6'b001100, 0, 0, 4'h1));
    step(mk("rst_valid", 0, 0, 0, 0, 1, 16'h1234, 0, 6'b000100, 0, 0, 0, 0));
    step(nx("rst_tx0", 6'b000110, 8'h34));
    RST = 1'b1;
    @(posedge CLK);
    #1;
    chk_reset("reset_mid_tx");
    RST = 1'b0;
    step(nx("rst_no_tx", 6'b000000));
    step(nx("rst_no_tx2", 6'b000000));
    step(rb("post_rd_cmd", 8'hBB, 6'b000000));
    step(rb("post_rd_addr", 8'h03, 6'b010000, 4'h3));
    step(mk("post_rd_valid", 0, 0, 1, 8'h77, 0, 0, 0, 6'b000000, 0, 0, 0, 0));
    step(nx("post_rd_tx", 6'b000010, 8'h77));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
